// File: rtl/pvt_meas_sequencer.sv
// PVT measurement sequencer: runs batches of start/settle/sample cycles against a DFF-ring
// measure block and presents avg (+ min/max when PVT_MEAS_MINMAX_EN is defined) with a valid/ready handshake.
module pvt_meas_sequencer #(
  parameter int CNT_WIDTH    = 8,
  parameter int SAMPLES_LOG2 = 2,
  parameter int WAIT_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 meas_start,
  input  logic [CNT_WIDTH-1:0] meas_cnt,
  output logic [CNT_WIDTH-1:0] result_avg,
  output logic [CNT_WIDTH-1:0] result_min,
  output logic [CNT_WIDTH-1:0] result_max,
  output logic                 result_err,
  output logic                 result_valid,
  input  logic                 result_ready
);
  localparam int SUM_W = CNT_WIDTH + SAMPLES_LOG2;
  localparam int WCW   = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, SAMPLE, OUTPUT} state_e;

  state_e                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [SAMPLES_LOG2-1:0] idx_q, idx_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    avg_q, avg_d;
  logic                    rerr_q, rerr_d;

  logic smp_en, last_smp, accept;
  assign smp_en   = (state_q == SAMPLE);
  assign last_smp = smp_en && (idx_q == '1);
  assign accept   = (state_q == OUTPUT) && result_ready;

  assign meas_start   = (state_q == START);
  assign result_valid = (state_q == OUTPUT);
  assign result_avg   = avg_q;
  assign result_err   = rerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      avg_q   <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      avg_q   <= avg_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    err_d   = err_q;
    avg_d   = avg_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE:  if (enable) state_d = START;
      START: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WCW'(WAIT_CYCLES - 1)) state_d = SAMPLE;
        else                                 wcnt_d  = wcnt_q + 1'b1;
      end
      SAMPLE: begin
        // A zero count means the ring never completed; it still counts toward the average.
        sum_d = sum_q + SUM_W'(meas_cnt);
        err_d = err_q | (meas_cnt == '0);
        idx_d = idx_q + 1'b1;
        if (last_smp) begin
          state_d = OUTPUT;
          avg_d   = CNT_WIDTH'(sum_d >> SAMPLES_LOG2);
          rerr_d  = err_d;
        end else begin
          state_d = START;
        end
      end
      OUTPUT: begin
        if (result_ready) begin
          sum_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = enable ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PVT_MEAS_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_WIDTH-1:0] rmin_q, rmin_d, rmax_q, rmax_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= '1;
      max_q  <= '0;
      rmin_q <= '0;
      rmax_q <= '0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      rmin_q <= rmin_d;
      rmax_q <= rmax_d;
    end
  end

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    rmin_d = rmin_q;
    rmax_d = rmax_q;
    if (smp_en) begin
      if (meas_cnt < min_q) min_d = meas_cnt;
      if (meas_cnt > max_q) max_d = meas_cnt;
      if (last_smp) begin
        rmin_d = min_d;
        rmax_d = max_d;
      end
    end else if (accept) begin
      min_d = '1;
      max_d = '0;
    end
  end

  assign result_min = rmin_q;
  assign result_max = rmax_q;
`else
  assign result_min = '0;
  assign result_max = '0;
`endif

endmodule

// File: tb/tb_pvt_meas_sequencer.sv
// Directed bench for pvt_meas_sequencer at default parameters; min/max expectations follow PVT_MEAS_MINMAX_EN.
module tb_pvt_meas_sequencer;
`ifdef PVT_MEAS_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable, result_ready;
  logic       meas_start, result_err, result_valid;
  logic [7:0] meas_cnt, result_avg, result_min, result_max;

  logic [7:0] tab [4];
  logic [1:0] sidx;
  int         nstart = 0;
  int         base   = 0;
  int         nerr   = 0;
  int         nchk   = 0;

  pvt_meas_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .meas_start   (meas_start),
    .meas_cnt     (meas_cnt),
    .result_avg   (result_avg),
    .result_min   (result_min),
    .result_max   (result_max),
    .result_err   (result_err),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  // Measure-block model: count start pulses; sample k of a batch returns tab[k].
  always @(posedge clk) if (meas_start) nstart <= nstart + 1;
  assign sidx     = 2'(nstart - base - 1);
  assign meas_cnt = tab[sidx];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_tab(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    tab[0] = a; tab[1] = b; tab[2] = c; tab[3] = d;
    base = nstart;
  endtask

  // Called right after the batch trigger (enable/ready/reset release) was driven on a negedge.
  task automatic go(input string tag, input bit drop);
    int cyc;
    @(negedge clk);
    result_ready = 1'b0;
    cyc = 1;
    chk({tag, "_vfall"}, 32'(result_valid), 0);
    chk({tag, "_start"}, 32'(meas_start), 1);
    while (!result_valid && cyc < 400) begin
      if (drop && (nstart - base) >= 2) enable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc - 1), 264);
    chk({tag, "_npulse"}, 32'(nstart - base), 4);
  endtask

  task automatic chk_res(input string tag, input int avg, input int mn, input int mx, input bit err);
    chk({tag, "_avg"}, 32'(result_avg), 32'(avg));
    chk({tag, "_err"}, 32'(result_err), 32'(err));
    chk({tag, "_min"}, 32'(result_min), MM ? 32'(mn) : 0);
    chk({tag, "_max"}, 32'(result_max), MM ? 32'(mx) : 0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; enable = 1'b0; result_ready = 1'b0;
    set_tab(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_start", 32'(meas_start), 0);
    chk_res("rst", 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_start", 32'(meas_start), 0);

    // A: constant 20, then hold with ready low
    set_tab(20, 20, 20, 20);
    enable = 1'b1;
    go("A", 1'b0);
    chk_res("A", 20, 20, 20, 1'b0);
    n0 = nstart;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(result_valid), 1);
      chk("hold_avg", 32'(result_avg), 20);
    end
    chk("hold_nostart", 32'(nstart - n0), 0);

    // B: mixed samples
    set_tab(10, 20, 30, 41);
    result_ready = 1'b1;
    go("B", 1'b0);
    chk_res("B", 25, 10, 41, 1'b0);

    // C: one zero sample raises the error flag
    set_tab(15, 0, 15, 15);
    result_ready = 1'b1;
    go("C", 1'b0);
    chk_res("C", 11, 0, 15, 1'b1);

    // E: enable dropped during sample 2; batch still completes
    set_tab(5, 6, 7, 8);
    result_ready = 1'b1;
    go("E", 1'b1);
    chk_res("E", 6, 5, 8, 1'b0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("E_acc_valid", 32'(result_valid), 0);
    chk("E_acc_start", 32'(meas_start), 0);
    repeat (150) @(negedge clk);
    chk("E_idle_pulses", 32'(nstart - base), 4);
    chk("E_idle_valid", 32'(result_valid), 0);
    chk("E_keep_avg", 32'(result_avg), 6);

    // F: reset during WAIT of sample 3 discards the partial batch
    set_tab(200, 200, 200, 200);
    enable = 1'b1;
    n0 = 0;
    while ((nstart - base) < 3 && n0 < 400) begin
      @(negedge clk);
      n0++;
    end
    chk("F_reach_s3", 32'(nstart - base), 3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("F_rst_valid", 32'(result_valid), 0);
    chk("F_rst_start", 32'(meas_start), 0);
    chk_res("F_rst", 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    set_tab(40, 40, 40, 44);
    rst_n = 1'b1;
    go("F", 1'b0);
    chk_res("F", 41, 40, 44, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
